// File: rtl/sc_window_scheduler_if.sv
// rtl/sc_window_scheduler_if.sv - Request/result bundle for the shared stochastic window counter
//
// Groups every handshake and data signal of sc_window_scheduler; clk/reset stay plain ports.
//   req_valid   [N_REQ]        per-requester conversion request
//   req_window  [N_REQ*WIDTH]  packed windows, requester i at [i*WIDTH +: WIDTH]
//   sb_in       [N_REQ]        per-requester stochastic bit, one sample per cycle
//   req_ready   [N_REQ]        one-hot accept, only while the scheduler is idle
//   res_valid                  result available
//   res_id      [ID_W]         requester the result belongs to
//   res_count   [WIDTH]        number of '1' samples seen in the window
//   res_ready                  consumer accepts result
//   busy                       scheduler is not idle
// master: the requester/consumer side. slave: the scheduler.
interface sc_window_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_window;
  logic [N_REQ-1:0]       sb_in;
  logic [N_REQ-1:0]       req_ready;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [WIDTH-1:0]       res_count;
  logic                   res_ready;
  logic                   busy;

  modport master (
    output req_valid, req_window, sb_in, res_ready,
    input  req_ready, res_valid, res_id, res_count, busy
  );

  modport slave (
    input  req_valid, req_window, sb_in, res_ready,
    output req_ready, res_valid, res_id, res_count, busy
  );
endinterface

// File: rtl/sc_window_scheduler.sv
// rtl/sc_window_scheduler.sv - Round-robin shared stochastic-to-binary window counter
//
// One counter is time-shared between N_REQ requesters. An idle scheduler grants the next
// requesting lane after the previous winner, counts the '1's on that lane's stochastic
// bitstream for exactly `window` cycles, then presents {id, count} on a valid/ready result.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any conversion in flight
//   bus    sc_window_scheduler_if.slave (request, stream, result and busy signals)
module sc_window_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sc_window_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  id;
  logic [WIDTH-1:0] win;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] elapsed;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_win;
  int               cand;

  logic             sb_bit;
  logic             last_sample;

  // Round-robin pick: scan N_REQ positions starting just after the last winner and
  // take the first requesting lane. The modulo keeps non-power-of-two N_REQ correct.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_win   = '0;
    cand        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(last_grant) + 1 + k) % N_REQ;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
        grant_win   = bus.req_window[cand*WIDTH +: WIDTH];
      end
    end
  end

  // Only the granted lane's stream is ever sampled.
  assign sb_bit      = bus.sb_in[id];
  // elapsed counts samples already taken, so the current cycle is the last one
  // when it has reached win-1 (win is never 0 here; zero windows skip COUNT).
  assign last_sample = (elapsed == (win - ONE));

  // Next state and the combinational one-hot accept.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    unique case (state)
      IDLE: begin
        if (grant_found) begin
          bus.req_ready[grant_idx] = 1'b1;
          state_nxt = (grant_win == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (last_sample) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath. last_grant resets to N_REQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ID_W'(N_REQ - 1);
      id         <= '0;
      win        <= '0;
      ones       <= '0;
      elapsed    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            id         <= grant_idx;
            win        <= grant_win;
            last_grant <= grant_idx;
            ones       <= '0;
            elapsed    <= '0;
          end
        end
        COUNT: begin
          ones    <= ones + {{(WIDTH-1){1'b0}}, sb_bit};
          elapsed <= elapsed + ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // id and ones are untouched in DONE, so the result holds steady under backpressure.
  assign bus.res_valid = (state == DONE);
  assign bus.res_id    = id;
  assign bus.res_count = ones;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sc_window_scheduler.sv
// tb/tb_sc_window_scheduler.sv - Self-checking bench for sc_window_scheduler
module tb_sc_window_scheduler;

  logic clk;
  logic reset;

  sc_window_scheduler_if #(.N_REQ(4), .WIDTH(32), .ID_W(2)) bus ();
  sc_window_scheduler_if #(.N_REQ(4), .WIDTH(8),  .ID_W(2)) b8 ();

  sc_window_scheduler #(.N_REQ(4), .WIDTH(32), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sc_window_scheduler #(.N_REQ(4), .WIDTH(8), .ID_W(2)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] win;
    logic [3:0]  mask;
    logic [15:0] seq;
    logic [1:0]  exp_id;
  } row_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] cnt;
  } exp_t;

  row_t rows [10];
  exp_t sb_q [$];

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [1:0] id, input logic [31:0] cnt);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_unexpected_result"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_res_id"}, 64'(id), 64'(e.id));
      chk({tag, "_res_count"}, 64'(cnt), 64'(e.cnt));
    end
  endtask

  // Entered in IDLE, #1 after an edge. Accept, stream win samples, take the result.
  task automatic run_row(input row_t r, input string tag);
    exp_t e;
    int   cnt;
    cnt = 0;
    for (int k = 0; k < int'(r.win); k++) begin
      if (r.mask[r.exp_id] && r.seq[k % 16]) cnt++;
    end
    bus.req_valid  = r.valid;
    bus.req_window = {4{r.win}};
    bus.sb_in      = 4'b0000;
    bus.res_ready  = 1'b1;
    #1;
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(4'b0001 << r.exp_id));
    chk({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    e.id  = r.exp_id;
    e.cnt = 32'(cnt);
    sb_q.push_back(e);
    tick();
    bus.req_valid = 4'b0000;
    for (int k = 0; k < int'(r.win); k++) begin
      bus.sb_in = r.seq[k % 16] ? r.mask : 4'b0000;
      #1;
      chk({tag, "_counting"}, 64'({bus.busy, bus.res_valid, bus.req_ready}), 64'(6'b100000));
      tick();
    end
    bus.sb_in = 4'b0000;
    chk({tag, "_res_valid_latency"}, 64'(bus.res_valid), 64'd1);
    if (bus.res_valid && bus.res_ready) begin
      pop_check(tag, bus.res_id, bus.res_count);
    end
    tick();
    chk({tag, "_back_idle"}, 64'({bus.busy, bus.res_valid}), 64'd0);
  endtask

  initial begin
    int n;
    exp_t e;
    n_cmp  = 0;
    n_fail = 0;

    rows[0] = '{valid: 4'hF,    win: 32'd4, mask: 4'b0100, seq: 16'hFFFF, exp_id: 2'd0};
    rows[1] = '{valid: 4'hF,    win: 32'd4, mask: 4'b0100, seq: 16'hFFFF, exp_id: 2'd1};
    rows[2] = '{valid: 4'hF,    win: 32'd4, mask: 4'b0100, seq: 16'hFFFF, exp_id: 2'd2};
    rows[3] = '{valid: 4'hF,    win: 32'd4, mask: 4'b0100, seq: 16'hFFFF, exp_id: 2'd3};
    rows[4] = '{valid: 4'hF,    win: 32'd4, mask: 4'b0100, seq: 16'hFFFF, exp_id: 2'd0};
    rows[5] = '{valid: 4'b0001, win: 32'd8, mask: 4'b0001, seq: 16'h004D, exp_id: 2'd0};
    rows[6] = '{valid: 4'b0010, win: 32'd0, mask: 4'b0010, seq: 16'hFFFF, exp_id: 2'd1};
    rows[7] = '{valid: 4'b1010, win: 32'd5, mask: 4'b1000, seq: 16'h0015, exp_id: 2'd3};
    rows[8] = '{valid: 4'b0101, win: 32'd3, mask: 4'b0001, seq: 16'hFFFF, exp_id: 2'd0};
    rows[9] = '{valid: 4'b1100, win: 32'd6, mask: 4'b1100, seq: 16'h003C, exp_id: 2'd2};

    bus.req_valid  = '0;
    bus.req_window = '0;
    bus.sb_in      = '0;
    bus.res_ready  = 1'b0;
    b8.req_valid   = '0;
    b8.req_window  = '0;
    b8.sb_in       = '0;
    b8.res_ready   = 1'b0;
    reset          = 1'b1;
    tick();
    do_reset();

    // Reset state
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_id",    64'(bus.res_id),    64'd0);
    chk("rst_res_count", 64'(bus.res_count), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

    // Table: round-robin order, pattern counting, zero window, rotation with gaps
    for (int i = 0; i < 10; i++) begin
      run_row(rows[i], $sformatf("row%0d", i));
    end

    // Backpressure in DONE with all requesters pending
    do_reset();
    bus.req_valid  = 4'hF;
    bus.req_window = {4{32'd2}};
    bus.sb_in      = 4'hF;
    bus.res_ready  = 1'b0;
    #1;
    chk("bp_req_ready", 64'(bus.req_ready), 64'(4'b0001));
    e.id  = 2'd0;
    e.cnt = 32'd2;
    sb_q.push_back(e);
    tick();
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", 64'({bus.res_valid, bus.busy, bus.req_ready, bus.res_id, bus.res_count}),
          64'({1'b1, 1'b1, 4'b0000, 2'd0, 32'd2}));
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    if (bus.res_valid && bus.res_ready) begin
      pop_check("bp", bus.res_id, bus.res_count);
    end else begin
      chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
    end
    tick();
    chk("bp_idle", 64'({bus.busy, bus.res_valid}), 64'd0);
    chk("bp_next_ready", 64'(bus.req_ready), 64'(4'b0010));
    run_row('{valid: 4'hF, win: 32'd1, mask: 4'b0000, seq: 16'h0000, exp_id: 2'd1}, "bp_next");

    // Reset in the middle of a conversion discards it
    do_reset();
    bus.req_valid  = 4'b0001;
    bus.req_window = {4{32'd10}};
    bus.sb_in      = 4'hF;
    bus.res_ready  = 1'b1;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    tick();
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_after", 64'({bus.busy, bus.res_valid}), 64'd0);
    tick();
    chk("abort_no_result", 64'({bus.busy, bus.res_valid}), 64'd0);
    run_row('{valid: 4'b0001, win: 32'd10, mask: 4'b0001, seq: 16'hFFFF, exp_id: 2'd0}, "abort_new");

    // WIDTH=8 full-scale window
    b8.req_valid  = 4'b0001;
    b8.req_window = {4{8'd255}};
    b8.sb_in      = 4'hF;
    b8.res_ready  = 1'b1;
    #1;
    chk("w8_req_ready", 64'(b8.req_ready), 64'(4'b0001));
    e.id  = 2'd0;
    e.cnt = 32'd255;
    sb_q.push_back(e);
    tick();
    b8.req_valid = 4'b0000;
    n = 0;
    while (!b8.res_valid && n < 400) begin
      tick();
      n++;
    end
    chk("w8_latency", 64'(n), 64'd255);
    if (b8.res_valid) begin
      pop_check("w8", b8.res_id, 32'(b8.res_count));
    end
    tick();
    chk("w8_idle", 64'({b8.busy, b8.res_valid}), 64'd0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
